// File: rtl/mem_bus_pkg.sv
// Shared types for the memory bus arbiter: FSM state encoding and the
// channel-index width helper.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   // Width of a channel index; never below one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after last_gnt+1,
// wrapping modulo N_CH.
module rr_arbiter
   import mem_bus_pkg::*;
#(
   parameter int N_CH = 2
) (
   input  logic [N_CH-1:0]          req,
   input  logic [idx_w(N_CH)-1:0]   last_gnt,
   output logic [idx_w(N_CH)-1:0]   gnt_idx,
   output logic                     gnt_vld
);

   localparam int GW = idx_w(N_CH);

   int best;

   // Each channel's distance from last_gnt+1; the smallest requesting distance wins.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      best    = N_CH;
      for (int j = 0; j < N_CH; j++) begin
         if (req[j] && (((j + 2 * N_CH - 1 - int'(last_gnt)) % N_CH) < best)) begin
            best    = (j + 2 * N_CH - 1 - int'(last_gnt)) % N_CH;
            gnt_idx = GW'(j);
            gnt_vld = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Multi-channel single-port memory arbiter: round-robin grant in IDLE, a
// WAIT_STATES+1 cycle memory access, then a one-cycle ack/err response.
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 16,
   parameter int N_CH        = 2,
   parameter int WAIT_STATES = 0,
   parameter int MEM_DEPTH   = 8192
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [N_CH-1:0]          ch_req,
   input  logic [N_CH-1:0]          ch_we,
   input  logic [N_CH*ADDR_W-1:0]   ch_addr,
   input  logic [N_CH*DATA_W-1:0]   ch_wdata,
   output logic [N_CH-1:0]          ch_ack,
   output logic [N_CH-1:0]          ch_err,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic [idx_w(N_CH)-1:0]   cur_gnt,
   output logic                     mem_en,
   output logic                     mem_rw,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W-1:0]        mem_din,
   input  logic [DATA_W-1:0]        mem_dout
);

   localparam int GW = idx_w(N_CH);

   state_t              state_q, state_d;
   logic [3:0]          wait_q, wait_d;
   logic [GW-1:0]       last_q, last_d;
   logic [GW-1:0]       gnt_q, gnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [ADDR_W-1:0]   addr_a  [N_CH];
   logic [DATA_W-1:0]   wdata_a [N_CH];
   logic [GW-1:0]       arb_idx;
   logic                arb_vld;

   always_comb begin
      for (int j = 0; j < N_CH; j++) begin
         addr_a[j]  = ch_addr[j*ADDR_W +: ADDR_W];
         wdata_a[j] = ch_wdata[j*DATA_W +: DATA_W];
      end
   end

   rr_arbiter #(.N_CH(N_CH)) u_rr (
      .req      (ch_req),
      .last_gnt (last_q),
      .gnt_idx  (arb_idx),
      .gnt_vld  (arb_vld)
   );

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      err_d   = err_q;
      rdata_d = rdata_q;
      if (en) begin
         case (state_q)
            IDLE: begin
               if (arb_vld) begin
                  gnt_d   = arb_idx;
                  we_d    = ch_we[arb_idx];
                  addr_d  = addr_a[arb_idx];
                  wdata_d = wdata_a[arb_idx];
                  wait_d  = 4'(WAIT_STATES);
                  // Out-of-range requests skip the memory entirely.
                  if (64'(addr_a[arb_idx]) < 64'(MEM_DEPTH)) begin
                     state_d = ACCESS;
                     err_d   = 1'b0;
                  end else begin
                     state_d = RESP;
                     err_d   = 1'b1;
                  end
               end
            end
            ACCESS: begin
               if (wait_q == 4'd0) state_d = RESP;
               else                wait_d  = wait_q - 4'd1;
            end
            RESP: begin
               state_d = IDLE;
               last_d  = gnt_q;
               if (err_q)      rdata_d = '0;
               else if (!we_q) rdata_d = mem_dout;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         wait_q  <= '0;
         last_q  <= GW'(N_CH - 1);
         gnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes are gated by en so a freeze never issues a memory cycle or ack.
   always_comb begin
      ch_ack   = '0;
      ch_err   = '0;
      ch_rdata = rdata_q;
      mem_en   = en && (state_q == ACCESS);
      mem_rw   = (state_q == ACCESS) && we_q;
      mem_addr = (state_q == ACCESS) ? addr_q : '0;
      mem_din  = (state_q == ACCESS) ? wdata_q : '0;
      if (en && (state_q == RESP)) begin
         ch_ack[gnt_q] = 1'b1;
         ch_err[gnt_q] = err_q;
         if (err_q)      ch_rdata = '0;
         else if (!we_q) ch_rdata = mem_dout;
      end
   end

   assign cur_gnt = gnt_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench: two arbiters (WAIT_STATES 0 and 2) with behavioural
// memories; stimulus pushes expected acks, a negedge monitor pops and compares.
module tb_mem_bus_arbiter;

   typedef struct {
      int          ch;
      logic        err;
      logic [15:0] rdata;
      int          cyc;
   } exp_t;

   logic        clk, rst, en;
   logic [1:0]  ch_req [2];
   logic [1:0]  ch_we  [2];
   logic [1:0]  ch_ack [2];
   logic [1:0]  ch_err [2];
   logic [31:0] ch_addr  [2];
   logic [31:0] ch_wdata [2];
   logic [15:0] ch_rdata [2];
   logic [15:0] mem_addr [2];
   logic [15:0] mem_din  [2];
   logic [15:0] mem_dout [2];
   logic        cur_gnt  [2];
   logic        mem_en   [2];
   logic        mem_rw   [2];
   logic [15:0] mem [2][8192];

   exp_t        q0[$];
   exp_t        q1[$];
   logic [15:0] exp_rq [2];
   int          men_cnt [2];
   int          wr_cnt  [2];
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;

   mem_bus_arbiter #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst(rst), .en(en),
      .ch_req(ch_req[0]), .ch_we(ch_we[0]), .ch_addr(ch_addr[0]), .ch_wdata(ch_wdata[0]),
      .ch_ack(ch_ack[0]), .ch_err(ch_err[0]), .ch_rdata(ch_rdata[0]), .cur_gnt(cur_gnt[0]),
      .mem_en(mem_en[0]), .mem_rw(mem_rw[0]), .mem_addr(mem_addr[0]), .mem_din(mem_din[0]),
      .mem_dout(mem_dout[0])
   );

   mem_bus_arbiter #(.WAIT_STATES(2)) dut2 (
      .clk(clk), .rst(rst), .en(en),
      .ch_req(ch_req[1]), .ch_we(ch_we[1]), .ch_addr(ch_addr[1]), .ch_wdata(ch_wdata[1]),
      .ch_ack(ch_ack[1]), .ch_err(ch_err[1]), .ch_rdata(ch_rdata[1]), .cur_gnt(cur_gnt[1]),
      .mem_en(mem_en[1]), .mem_rw(mem_rw[1]), .mem_addr(mem_addr[1]), .mem_din(mem_din[1]),
      .mem_dout(mem_dout[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous-read memories, preloaded while reset is held.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst) begin
            mem[i][16'h0010] <= 16'hBEEF;
            mem[i][16'h0011] <= 16'hCAFE;
            mem[i][16'h0030] <= 16'h5A5A;
         end else if (mem_en[i]) begin
            if (mem_rw[i]) mem[i][mem_addr[i][12:0]] <= mem_din[i];
            else           mem_dout[i] <= mem[i][mem_addr[i][12:0]];
         end
      end
   end

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (dut%0d): got 0x%0h, expected 0x%0h at cycle %0d", name, i, act, exp, cyc);
      end
   endtask

   task automatic check_ack(input int i);
      exp_t e;
      int   n;
      n = (i == 0) ? q0.size() : q1.size();
      if (n == 0) begin
         chk("unexpected_ack", i, 32'(ch_ack[i]), 32'd0);
      end else begin
         e = (i == 0) ? q0.pop_front() : q1.pop_front();
         chk("ack_vec",   i, 32'(ch_ack[i]), 32'(2'b01 << e.ch));
         chk("ack_err",   i, 32'(ch_err[i]), e.err ? 32'(2'b01 << e.ch) : 32'd0);
         chk("ack_rdata", i, 32'(ch_rdata[i]), 32'(e.rdata));
         chk("ack_cycle", i, cyc, e.cyc);
      end
   endtask

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mem_en[i]) men_cnt[i]++;
         if (mem_en[i] && mem_rw[i]) wr_cnt[i]++;
         if (rst && ch_ack[i] != 2'b00) check_ack(i);
      end
   end

   task automatic push_exp(input int i, input int ch, input logic we, input logic [15:0] addr,
                           input logic [15:0] rd, input int extra);
      exp_t e;
      e.ch  = ch;
      e.err = (addr >= 16'h2000);
      if (e.err)    e.rdata = 16'h0;
      else if (we)  e.rdata = exp_rq[i];
      else          e.rdata = rd;
      if (e.err || !we) exp_rq[i] = e.rdata;
      e.cyc = cyc + (e.err ? 1 : ((i == 1) ? 2 : 0) + 2) + extra;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic drive(input int i, input int ch, input logic we, input logic [15:0] addr,
                        input logic [15:0] wd);
      ch_we[i][ch]             = we;
      ch_addr[i][ch*16 +: 16]  = addr;
      ch_wdata[i][ch*16 +: 16] = wd;
      ch_req[i][ch]            = 1'b1;
   endtask

   task automatic start_req(input int i, input int ch, input logic we, input logic [15:0] addr,
                            input logic [15:0] wd, input logic [15:0] rd, input int extra);
      push_exp(i, ch, we, addr, rd, extra);
      drive(i, ch, we, addr, wd);
   endtask

   // Hold the request until its ack, then drop it early in the following IDLE cycle.
   task automatic wait_ack(input int i, input int ch);
      logic got;
      got = 1'b0;
      for (int k = 0; k < 64 && !got; k++) begin
         @(negedge clk);
         if (ch_ack[i][ch]) got = 1'b1;
      end
      if (!got) chk("ack_timeout", i, 32'd0, 32'd1);
      @(posedge clk); #1;
      ch_req[i][ch] = 1'b0;
   endtask

   initial begin
      int base, n;
      rst = 1'b0;
      en  = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ch_req[i] = '0; ch_we[i] = '0; ch_addr[i] = '0; ch_wdata[i] = '0;
         exp_rq[i] = '0; men_cnt[i] = 0; wr_cnt[i] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         chk("rst_ack",    i, 32'(ch_ack[i]), 32'd0);
         chk("rst_mem_en", i, 32'(mem_en[i]), 32'd0);
         chk("rst_gnt",    i, 32'(cur_gnt[i]), 32'd0);
         chk("rst_rdata",  i, 32'(ch_rdata[i]), 32'd0);
      end
      rst = 1'b1;
      @(posedge clk); #1;

      // Both channels request continuously: grants 0,1,0,1 three cycles apart.
      base = men_cnt[0];
      push_exp(0, 0, 1'b0, 16'h0010, 16'hBEEF, 0);
      push_exp(0, 1, 1'b0, 16'h0011, 16'hCAFE, 3);
      push_exp(0, 0, 1'b0, 16'h0010, 16'hBEEF, 6);
      push_exp(0, 1, 1'b0, 16'h0011, 16'hCAFE, 9);
      drive(0, 0, 1'b0, 16'h0010, 16'h0);
      drive(0, 1, 1'b0, 16'h0011, 16'h0);
      n = 0;
      for (int k = 0; k < 64 && n < 4; k++) begin
         @(negedge clk);
         if (ch_ack[0] != 2'b00) n++;
      end
      @(posedge clk); #1;
      ch_req[0] = 2'b00;
      chk("fair_acks",   0, n, 4);
      chk("fair_mem_en", 0, men_cnt[0] - base, 4);

      // Single read with zero wait states.
      base = men_cnt[0];
      start_req(0, 0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 0);
      wait_ack(0, 0);
      chk("rd_mem_en", 0, men_cnt[0] - base, 1);

      // Out-of-range read: immediate error ack, no memory cycle, rdata cleared.
      base = men_cnt[0];
      start_req(0, 0, 1'b0, 16'h2000, 16'h0, 16'h0, 0);
      wait_ack(0, 0);
      chk("oor_mem_en", 0, men_cnt[0] - base, 0);
      chk("oor_rdata",  0, 32'(ch_rdata[0]), 32'd0);
      chk("oor_gnt",    0, 32'(cur_gnt[0]), 32'd0);

      // Request altered and dropped mid-access: the latched read still completes.
      start_req(0, 1, 1'b0, 16'h0011, 16'h0, 16'hCAFE, 0);
      @(posedge clk); #1;
      ch_addr[0][31:16] = 16'h0010;
      ch_req[0][1] = 1'b0;
      wait_ack(0, 1);
      chk("chg_gnt",   0, 32'(cur_gnt[0]), 32'd1);
      chk("chg_rdata", 0, 32'(ch_rdata[0]), 32'hCAFE);

      // Three-cycle freeze in the middle of a two-wait-state read.
      base = men_cnt[1];
      start_req(1, 0, 1'b0, 16'h0030, 16'h0, 16'h5A5A, 3);
      repeat (2) begin @(posedge clk); #1; end
      en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("frz_mem_en", 1, 32'(mem_en[1]), 32'd0);
      end
      @(posedge clk); #1;
      en = 1'b1;
      wait_ack(1, 0);
      chk("frz_mem_cnt", 1, men_cnt[1] - base, 3);

      // Write keeps the previous read data; then read it back.
      base = wr_cnt[1];
      start_req(1, 1, 1'b1, 16'h0020, 16'h1234, 16'h0, 0);
      wait_ack(1, 1);
      chk("wr_cycles", 1, wr_cnt[1] - base, 3);
      start_req(1, 0, 1'b0, 16'h0020, 16'h0, 16'h1234, 0);
      wait_ack(1, 0);

      // Reset in the middle of an access: no ack, outputs cleared at once.
      drive(1, 0, 1'b0, 16'h0030, 16'h0);
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b0;
      #1;
      chk("rst_mid_mem_en", 1, 32'(mem_en[1]), 32'd0);
      chk("rst_mid_addr",   1, 32'(mem_addr[1]), 32'd0);
      chk("rst_mid_rdata",  1, 32'(ch_rdata[1]), 32'd0);
      chk("rst_mid_ack",    1, 32'(ch_ack[1]), 32'd0);
      chk("rst_mid_rdata",  0, 32'(ch_rdata[0]), 32'd0);
      ch_req[1] = 2'b00;
      exp_rq[0] = '0;
      exp_rq[1] = '0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      start_req(1, 0, 1'b0, 16'h0010, 16'h0, 16'hBEEF, 0);
      wait_ack(1, 0);

      repeat (4) @(posedge clk);
      #1;
      chk("sb_left", 0, q0.size(), 0);
      chk("sb_left", 1, q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
